// File: rtl/soft_cpu_dbg_pkg.sv
// Shared types and constants for the soft-core CPU debug wrapper:
// enable-FSM state encoding and active-low gfedcba segment codes.
package soft_cpu_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } en_state_e;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/soft_core_cpu_debug_top_hex_seg7.sv
// One hex digit to active-low 7-segment pattern (gfedcba).
module hex_seg7
   import soft_cpu_dbg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_0;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_0;
      endcase
   end

endmodule

// File: rtl/soft_core_cpu_debug_top.sv
// CPU debug wrapper: run/step/breakpoint clock enable, circular capture of
// CPU output strobes, and a hex display of PC-1 plus two history entries.
module soft_core_cpu_debug_top
   import soft_cpu_dbg_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8,
   parameter int DEPTH  = 8
) (
   input  logic                                   CLK,
   input  logic                                   CLR,
   input  logic                                   DOUT,
   input  logic [DATA_W-1:0]                      RESULT,
   input  logic [PC_W-1:0]                        PC,
   input  logic                                   RUN,
   input  logic                                   STEP,
   input  logic                                   BRK_EN,
   input  logic [PC_W-1:0]                        BRK_PC,
   input  logic                                   BROWSE,
   input  logic                                   BROWSE_NEXT,
   output logic                                   CPU_EN,
   output logic                                   HALTED,
   output logic [$clog2(DEPTH):0]                 HIST_CNT,
   output logic [7*(PC_W/4+2*(DATA_W/4))-1:0]     SEG
);

   localparam int AW   = $clog2(DEPTH);
   localparam int NDIG = PC_W/4 + 2*(DATA_W/4);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic                dout_q, step_q, next_q;
   logic                dout_e, step_e, next_e;
   en_state_e           state;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wp, off;
   logic [AW:0]         age0, age1;
   logic [AW-1:0]       idx0, idx1;
   logic [DATA_W-1:0]   d0, d1;
   logic [PC_W-1:0]     pc_m1;
   logic [4*NDIG-1:0]   disp;

   assign dout_e = DOUT & ~dout_q;
   assign step_e = STEP & ~step_q;
   assign next_e = BROWSE_NEXT & ~next_q;

   // Edge detectors, history write side and browse offset
   always_ff @(posedge CLK) begin
      if (CLR) begin
         dout_q   <= 1'b0;
         step_q   <= 1'b0;
         next_q   <= 1'b0;
         wp       <= '0;
         off      <= '0;
         HIST_CNT <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         dout_q <= DOUT;
         step_q <= STEP;
         next_q <= BROWSE_NEXT;
         if (dout_e) begin
            mem[wp] <= RESULT;
            wp      <= wp + 1'b1;
            if (HIST_CNT != FULL_CNT) HIST_CNT <= HIST_CNT + 1'b1;
         end
         // Wrap is judged against the count before any same-cycle capture
         if (!BROWSE)     off <= '0;
         else if (next_e) off <= (age1 < HIST_CNT) ? age1[AW-1:0] : '0;
      end
   end

   // Enable FSM: breakpoint outranks step, step outranks the run level
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state  <= ST_IDLE;
         CPU_EN <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (RUN) begin
                  state  <= ST_RUN;
                  CPU_EN <= 1'b1;
               end else begin
                  CPU_EN <= step_e;
               end
            end
            ST_RUN: begin
               if (BRK_EN && (PC == BRK_PC)) begin
                  state  <= ST_HALT;
                  CPU_EN <= 1'b0;
               end else if (!RUN) begin
                  state  <= ST_IDLE;
                  CPU_EN <= 1'b0;
               end else begin
                  CPU_EN <= 1'b1;
               end
            end
            ST_HALT: begin
               CPU_EN <= step_e;
               if (!RUN) state <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               CPU_EN <= 1'b0;
            end
         endcase
      end
   end

   assign HALTED = (state == ST_HALT);

   // Live mode is simply off == 0, which the offset register holds while BROWSE is low
   assign age0  = {1'b0, off};
   assign age1  = age0 + 1'b1;
   assign idx0  = wp - 1'b1 - off;
   assign idx1  = idx0 - 1'b1;
   assign d0    = (age0 < HIST_CNT) ? mem[idx0] : '0;
   assign d1    = (age1 < HIST_CNT) ? mem[idx1] : '0;
   assign pc_m1 = PC - 1'b1;
   assign disp  = {pc_m1, d1, d0};

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      hex_seg7 u_hex (
         .hex (disp[4*g +: 4]),
         .seg (SEG[7*g +: 7])
      );
   end

endmodule
